// File: rtl/axis_pkg.sv
// -----------------------------------------------------------------------------
// axis_pkg
// Shared helpers for the AXI-Stream style blocks.
//   clog2(value)   : ceiling log2 of an integer, 0 for value <= 1
//   idx_width(n)   : bit width of a counter that spans 0..n-1, never below 1
// -----------------------------------------------------------------------------
package axis_pkg;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    function automatic int idx_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/axis_packer_accum.sv
// -----------------------------------------------------------------------------
// axis_packer_accum
// Lane counter and accumulator for the narrow-to-wide packer.
// Optional feature macro: AXIS_PACKER_KEEP_EN (adds per-lane keep tracking).
//
// Ports
//   clk, rst       : clock, asynchronous active-low reset
//   beat_fire      : a narrow beat is accepted this cycle
//   up_data        : narrow beat payload
//   up_last        : accepted beat ends the packet
//   hold_word      : the completing word cannot leave now, park it here
//   flush          : the parked word is moving to the output register
//   merged_keep    : keep of the accumulator including the current beat
//   acc_keep       : keep of the parked word
//   complete       : current accepted beat finishes a word
//   merged_data    : accumulator including the current beat
//   acc_data       : parked word payload
//   acc_last       : parked word last flag
// -----------------------------------------------------------------------------
module axis_packer_accum
    import axis_pkg::*;
#(
    parameter int DATA_NB    = 3,
    parameter int DATA_WIDTH = 8,
    parameter int MSB_FIRST  = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          beat_fire,
    input  logic [DATA_WIDTH-1:0]         up_data,
    input  logic                          up_last,
    input  logic                          hold_word,
    input  logic                          flush,
`ifdef AXIS_PACKER_KEEP_EN
    output logic [DATA_NB-1:0]            merged_keep,
    output logic [DATA_NB-1:0]            acc_keep,
`endif
    output logic                          complete,
    output logic [DATA_NB*DATA_WIDTH-1:0] merged_data,
    output logic [DATA_NB*DATA_WIDTH-1:0] acc_data,
    output logic                          acc_last
);

    localparam int IW = idx_width(DATA_NB);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_NB - 1);

    logic [IW-1:0]                 idx_q, idx_d;
    logic [IW-1:0]                 lane;
    logic [DATA_NB*DATA_WIDTH-1:0] acc_data_q, acc_data_d;
    logic                          acc_last_q, acc_last_d;
`ifdef AXIS_PACKER_KEEP_EN
    logic [DATA_NB-1:0]            acc_keep_q, acc_keep_d;
`endif

    always_comb begin
        lane        = (MSB_FIRST != 0) ? (LAST_IDX - idx_q) : idx_q;
        complete    = beat_fire && ((idx_q == LAST_IDX) || up_last);

        // Unfilled lanes are zero in the accumulator, so the current beat
        // can simply be dropped into its lane.
        merged_data = acc_data_q;
        if (beat_fire) begin
            merged_data[int'(lane)*DATA_WIDTH +: DATA_WIDTH] = up_data;
        end
`ifdef AXIS_PACKER_KEEP_EN
        merged_keep = acc_keep_q;
        if (beat_fire) begin
            merged_keep[int'(lane)] = 1'b1;
        end
        acc_keep_d  = acc_keep_q;
`endif

        idx_d       = idx_q;
        acc_data_d  = acc_data_q;
        acc_last_d  = acc_last_q;

        if (flush) begin
            acc_data_d = '0;
            acc_last_d = 1'b0;
`ifdef AXIS_PACKER_KEEP_EN
            acc_keep_d = '0;
`endif
        end else if (beat_fire) begin
            if (complete) begin
                idx_d = '0;
                if (hold_word) begin
                    // Output register busy: the finished word waits here.
                    // No beats are accepted until it has been flushed.
                    acc_data_d = merged_data;
                    acc_last_d = up_last;
`ifdef AXIS_PACKER_KEEP_EN
                    acc_keep_d = merged_keep;
`endif
                end else begin
                    acc_data_d = '0;
                    acc_last_d = 1'b0;
`ifdef AXIS_PACKER_KEEP_EN
                    acc_keep_d = '0;
`endif
                end
            end else begin
                idx_d      = idx_q + IW'(1);
                acc_data_d = merged_data;
`ifdef AXIS_PACKER_KEEP_EN
                acc_keep_d = merged_keep;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q      <= '0;
            acc_data_q <= '0;
            acc_last_q <= 1'b0;
`ifdef AXIS_PACKER_KEEP_EN
            acc_keep_q <= '0;
`endif
        end else begin
            idx_q      <= idx_d;
            acc_data_q <= acc_data_d;
            acc_last_q <= acc_last_d;
`ifdef AXIS_PACKER_KEEP_EN
            acc_keep_q <= acc_keep_d;
`endif
        end
    end

    assign acc_data = acc_data_q;
    assign acc_last = acc_last_q;
`ifdef AXIS_PACKER_KEEP_EN
    assign acc_keep = acc_keep_q;
`endif

endmodule

// File: rtl/axis_packer.sv
// -----------------------------------------------------------------------------
// axis_packer
// Packs DATA_NB narrow stream beats into one wide stream word.
// Optional feature macro: AXIS_PACKER_KEEP_EN (adds the down_keep port).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits for ready, and payload is held stable while
// valid is high and ready is low.
//
// Ports
//   clk         : clock, rising edge
//   rst         : asynchronous active-low reset
//   up_data     : narrow beat payload (DATA_WIDTH)
//   up_valid    : narrow beat valid
//   up_ready    : packer accepts a beat (registered)
//   up_last     : narrow beat ends the packet
//   down_data   : packed word (DATA_NB*DATA_WIDTH), unfilled lanes zero
//   down_keep   : per-lane filled mask (only with AXIS_PACKER_KEEP_EN)
//   down_valid  : packed word valid
//   down_ready  : downstream accepts the word
//   down_last   : packed word ends the packet
// -----------------------------------------------------------------------------
module axis_packer
    import axis_pkg::*;
#(
    parameter int DATA_NB    = 3,
    parameter int DATA_WIDTH = 8,
    parameter int MSB_FIRST  = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         up_data,
    input  logic                          up_valid,
    output logic                          up_ready,
    input  logic                          up_last,
    output logic [DATA_NB*DATA_WIDTH-1:0] down_data,
`ifdef AXIS_PACKER_KEEP_EN
    output logic [DATA_NB-1:0]            down_keep,
`endif
    output logic                          down_valid,
    input  logic                          down_ready,
    output logic                          down_last
);

    logic                          up_ready_q, up_ready_d;
    logic                          pending_q, pending_d;
    logic                          down_valid_q, down_valid_d;
    logic                          down_last_q, down_last_d;
    logic [DATA_NB*DATA_WIDTH-1:0] down_data_q, down_data_d;
`ifdef AXIS_PACKER_KEEP_EN
    logic [DATA_NB-1:0]            down_keep_q, down_keep_d;
    logic [DATA_NB-1:0]            merged_keep;
    logic [DATA_NB-1:0]            acc_keep;
`endif

    logic                          beat_fire;
    logic                          can_load;
    logic                          hold_word;
    logic                          flush;
    logic                          complete;
    logic [DATA_NB*DATA_WIDTH-1:0] merged_data;
    logic [DATA_NB*DATA_WIDTH-1:0] acc_data;
    logic                          acc_last;

    assign beat_fire = up_valid && up_ready_q;
    // Output register is free when empty or being drained this edge.
    assign can_load  = !down_valid_q || down_ready;
    assign hold_word = complete && !can_load;
    assign flush     = pending_q && can_load;

    axis_packer_accum #(
        .DATA_NB    (DATA_NB),
        .DATA_WIDTH (DATA_WIDTH),
        .MSB_FIRST  (MSB_FIRST)
    ) u_accum (
        .clk         (clk),
        .rst         (rst),
        .beat_fire   (beat_fire),
        .up_data     (up_data),
        .up_last     (up_last),
        .hold_word   (hold_word),
        .flush       (flush),
`ifdef AXIS_PACKER_KEEP_EN
        .merged_keep (merged_keep),
        .acc_keep    (acc_keep),
`endif
        .complete    (complete),
        .merged_data (merged_data),
        .acc_data    (acc_data),
        .acc_last    (acc_last)
    );

    always_comb begin
        pending_d    = pending_q;
        down_valid_d = down_valid_q;
        down_data_d  = down_data_q;
        down_last_d  = down_last_q;
`ifdef AXIS_PACKER_KEEP_EN
        down_keep_d  = down_keep_q;
`endif

        if (flush) begin
            // up_ready is low while pending, so no beat competes here.
            pending_d    = 1'b0;
            down_valid_d = 1'b1;
            down_data_d  = acc_data;
            down_last_d  = acc_last;
`ifdef AXIS_PACKER_KEEP_EN
            down_keep_d  = acc_keep;
`endif
        end else if (complete && can_load) begin
            down_valid_d = 1'b1;
            down_data_d  = merged_data;
            down_last_d  = up_last;
`ifdef AXIS_PACKER_KEEP_EN
            down_keep_d  = merged_keep;
`endif
        end else if (complete) begin
            pending_d    = 1'b1;
        end else if (down_ready) begin
            down_valid_d = 1'b0;
        end

        // Registered ready: depends only on next-state, never on inputs
        // of the current cycle reaching the port directly.
        up_ready_d = !pending_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            up_ready_q   <= 1'b0;
            pending_q    <= 1'b0;
            down_valid_q <= 1'b0;
            down_data_q  <= '0;
            down_last_q  <= 1'b0;
`ifdef AXIS_PACKER_KEEP_EN
            down_keep_q  <= '0;
`endif
        end else begin
            up_ready_q   <= up_ready_d;
            pending_q    <= pending_d;
            down_valid_q <= down_valid_d;
            down_data_q  <= down_data_d;
            down_last_q  <= down_last_d;
`ifdef AXIS_PACKER_KEEP_EN
            down_keep_q  <= down_keep_d;
`endif
        end
    end

    assign up_ready   = up_ready_q;
    assign down_valid = down_valid_q;
    assign down_data  = down_data_q;
    assign down_last  = down_last_q;
`ifdef AXIS_PACKER_KEEP_EN
    assign down_keep  = down_keep_q;
`endif

endmodule

// File: tb/tb_axis_packer.sv
// -----------------------------------------------------------------------------
// tb_axis_packer
// Drives two packers (LSB-first and MSB-first) from the same stream and checks
// their output words against a packet-level model of the packing rules.
// Optional feature macro: AXIS_PACKER_KEEP_EN (keep checks enabled).
// -----------------------------------------------------------------------------
module tb_axis_packer;

    localparam int NB = 3;
    localparam int DW = 8;
    localparam int WW = NB * DW;

    logic          clk;
    logic          rst;
    logic [DW-1:0] up_data;
    logic          up_valid;
    logic          up_last;
    logic          down_ready;

    logic          up_ready0, up_ready1;
    logic [WW-1:0] dd0, dd1;
    logic          dv0, dv1;
    logic          dl0, dl1;
`ifdef AXIS_PACKER_KEEP_EN
    logic [NB-1:0] dk0, dk1;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model state: beats of the word being built, expected words per DUT.
    logic [DW-1:0] beats[$];
    logic [WW-1:0] exp0_q[$];
    logic [WW-1:0] exp1_q[$];
    logic          expl_q[$];
    logic [NB-1:0] expk0_q[$];
    logic [NB-1:0] expk1_q[$];

    // Observed transfers.
    logic [WW-1:0] rx0_q[$];
    logic [WW-1:0] rx1_q[$];
    int            rx0_cyc[$];

    // Stability tracking while stalled.
    bit            hold_pending = 0;
    logic [WW-1:0] hold_data;
    logic          hold_last;

    axis_packer #(.DATA_NB(NB), .DATA_WIDTH(DW), .MSB_FIRST(0)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .up_data    (up_data),
        .up_valid   (up_valid),
        .up_ready   (up_ready0),
        .up_last    (up_last),
        .down_data  (dd0),
`ifdef AXIS_PACKER_KEEP_EN
        .down_keep  (dk0),
`endif
        .down_valid (dv0),
        .down_ready (down_ready),
        .down_last  (dl0)
    );

    axis_packer #(.DATA_NB(NB), .DATA_WIDTH(DW), .MSB_FIRST(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .up_data    (up_data),
        .up_valid   (up_valid),
        .up_ready   (up_ready1),
        .up_last    (up_last),
        .down_data  (dd1),
`ifdef AXIS_PACKER_KEEP_EN
        .down_keep  (dk1),
`endif
        .down_valid (dv1),
        .down_ready (down_ready),
        .down_last  (dl1)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- check helper ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- model ----------------
    task automatic model_accept(input logic [DW-1:0] d, input logic l);
        logic [WW-1:0] w0, w1;
        logic [NB-1:0] k0, k1;
        beats.push_back(d);
        if (beats.size() == NB || l) begin
            w0 = '0; w1 = '0; k0 = '0; k1 = '0;
            for (int i = 0; i < beats.size(); i++) begin
                w0[i*DW +: DW]        = beats[i];
                w1[(NB-1-i)*DW +: DW] = beats[i];
                k0[i]                 = 1'b1;
                k1[NB-1-i]            = 1'b1;
            end
            exp0_q.push_back(w0);
            exp1_q.push_back(w1);
            expl_q.push_back(l);
            expk0_q.push_back(k0);
            expk1_q.push_back(k1);
            beats.delete();
        end
    endtask

    // ---------------- driver: one clock cycle ----------------
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic l,
                         input logic dr, output bit acc);
        logic [WW-1:0] e;
        up_valid   = v;
        up_data    = d;
        up_last    = l;
        down_ready = dr;
        @(negedge clk);
        acc = v && up_ready0 && rst;

        if (hold_pending) begin
            chk("hold_valid", 32'(dv0), 32'd1);
            chk("hold_data", 32'(dd0), 32'(hold_data));
            chk("hold_last", 32'(dl0), 32'(hold_last));
        end
        hold_pending = dv0 && !dr;
        hold_data    = dd0;
        hold_last    = dl0;

        if (dv0 && dr) begin
            rx0_q.push_back(dd0);
            rx0_cyc.push_back(cyc);
            chk("dut0_has_expected", 32'(exp0_q.size() > 0), 32'd1);
            if (exp0_q.size() > 0) begin
                e = exp0_q.pop_front();
                chk("dut0_data", 32'(dd0), 32'(e));
                chk("dut0_last", 32'(dl0), 32'(expl_q[0]));
`ifdef AXIS_PACKER_KEEP_EN
                chk("dut0_keep", 32'(dk0), 32'(expk0_q[0]));
`endif
                void'(expl_q.pop_front());
                void'(expk0_q.pop_front());
            end
        end
        if (dv1 && dr) begin
            rx1_q.push_back(dd1);
            chk("dut1_has_expected", 32'(exp1_q.size() > 0), 32'd1);
            if (exp1_q.size() > 0) begin
                e = exp1_q.pop_front();
                chk("dut1_data", 32'(dd1), 32'(e));
                chk("dut1_last", 32'(dl1), 32'(dl0));
`ifdef AXIS_PACKER_KEEP_EN
                chk("dut1_keep", 32'(dk1), 32'(expk1_q[0]));
`endif
                void'(expk1_q.pop_front());
            end
        end

        if (acc) model_accept(d, l);

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b1, acc);
    endtask

    // Sends n beats first, first+1, ... ; returns cycles spent.
    task automatic send_beats(input int n, input logic [DW-1:0] first,
                              input bit last_end, input bit dr, output int used);
        bit acc;
        int sent;
        sent = 0;
        used = 0;
        while (sent < n && used < 200) begin
            cycle(1'b1, first + DW'(sent), last_end && (sent == n - 1), dr, acc);
            if (acc) sent++;
            used++;
        end
        chk("send_done", 32'(sent), 32'(n));
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        chk("rst_dv0", 32'(dv0), 32'd0);
        chk("rst_dd0", 32'(dd0), 32'd0);
        chk("rst_dl0", 32'(dl0), 32'd0);
        chk("rst_dv1", 32'(dv1), 32'd0);
        chk("rst_dd1", 32'(dd1), 32'd0);
        chk("rst_ur0", 32'(up_ready0), 32'd0);
`ifdef AXIS_PACKER_KEEP_EN
        chk("rst_dk0", 32'(dk0), 32'd0);
`endif
        beats.delete();
        exp0_q.delete(); exp1_q.delete(); expl_q.delete();
        expk0_q.delete(); expk1_q.delete();
        hold_pending = 0;
        up_valid = 1'b0; up_last = 1'b0; down_ready = 1'b1; up_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_ur0", 32'(up_ready0), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        chk("rel_ur0", 32'(up_ready0), 32'd1);
        chk("rel_ur1", 32'(up_ready1), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int  used;
        int  base0, base1;
        int  cnt;
        bit  acc;
        logic [DW-1:0] nxt;

        rst = 1'b1; up_valid = 1'b0; up_data = '0; up_last = 1'b0; down_ready = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        // Plain stream 0x01..0x06, no last: full words, no bubbles.
        base0 = rx0_q.size(); base1 = rx1_q.size();
        send_beats(6, 8'h01, 1'b0, 1'b1, used);
        chk("stream_no_bubble", 32'(used), 32'd6);
        idle(3);
        chk("lsb_count", 32'(rx0_q.size() - base0), 32'd2);
        if (rx0_q.size() >= base0 + 2) begin
            chk("lsb_w0", 32'(rx0_q[base0]), 32'h030201);
            chk("lsb_w1", 32'(rx0_q[base0+1]), 32'h060504);
        end
        if (rx1_q.size() >= base1 + 2) begin
            chk("msb_w0", 32'(rx1_q[base1]), 32'h010203);
            chk("msb_w1", 32'(rx1_q[base1+1]), 32'h040506);
        end

        // 0x01..0x05 with last on 0x05, then a new packet 0x07.
        base0 = rx0_q.size();
        send_beats(5, 8'h01, 1'b1, 1'b1, used);
        send_beats(1, 8'h07, 1'b1, 1'b1, used);
        idle(3);
        chk("pkt_count", 32'(rx0_q.size() - base0), 32'd3);
        if (rx0_q.size() >= base0 + 3) begin
            chk("pkt_w0", 32'(rx0_q[base0]), 32'h030201);
            chk("pkt_w1", 32'(rx0_q[base0+1]), 32'h000504);
            chk("pkt_w2", 32'(rx0_q[base0+2]), 32'h000007);
        end

        // Downstream stalled for 12 cycles with up_valid held high.
        nxt = 8'h01;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, nxt, 1'b0, 1'b0, acc);
            if (acc) begin
                nxt = nxt + 8'h01;
                cnt++;
            end
        end
        chk("stall_accepted", 32'(cnt), 32'd6);
        chk("stall_ur0", 32'(up_ready0), 32'd0);
        chk("stall_dv0", 32'(dv0), 32'd1);
        chk("stall_dd0", 32'(dd0), 32'h030201);
        base0 = rx0_q.size();
        idle(4);
        chk("b2b_count", 32'(rx0_q.size() - base0), 32'd2);
        if (rx0_q.size() >= base0 + 2) begin
            chk("b2b_w0", 32'(rx0_q[base0]), 32'h030201);
            chk("b2b_w1", 32'(rx0_q[base0+1]), 32'h060504);
            chk("b2b_gap", 32'(rx0_cyc[base0+1] - rx0_cyc[base0]), 32'd1);
        end
        chk("b2b_ur0", 32'(up_ready0), 32'd1);

        // Reset in the middle of a word.
        send_beats(2, 8'h01, 1'b0, 1'b1, used);
        do_reset();
        base0 = rx0_q.size();
        send_beats(3, 8'h07, 1'b0, 1'b1, used);
        idle(3);
        chk("after_rst_count", 32'(rx0_q.size() - base0), 32'd1);
        if (rx0_q.size() >= base0 + 1) chk("after_rst_w", 32'(rx0_q[base0]), 32'h090807);

        // Single-beat packet: word visible one cycle after acceptance.
        cycle(1'b1, 8'h0A, 1'b1, 1'b1, acc);
        chk("single_acc", 32'(acc), 32'd1);
        chk("single_dv", 32'(dv0), 32'd1);
        chk("single_dd", 32'(dd0), 32'h00000A);
        chk("single_dl", 32'(dl0), 32'd1);
`ifdef AXIS_PACKER_KEEP_EN
        chk("single_dk", 32'(dk0), 32'b001);
`endif
        idle(2);
        chk("drop_dv", 32'(dv0), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 4) == 0,
                  $urandom_range(0, 3) != 0, acc);
        end
        // Finish any open word, then drain.
        send_beats(1, 8'hEE, 1'b1, 1'b1, used);
        idle(6);
        chk("drain_exp0", 32'(exp0_q.size()), 32'd0);
        chk("drain_exp1", 32'(exp1_q.size()), 32'd0);
        chk("drain_dv0", 32'(dv0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_packer.md
AXIS_PACKER -- requirements
Module: axis_packer

Interface
REQ-001 Parameter DATA_NB, default 3, number of narrow beats packed per wide word (>=2).
REQ-002 Parameter DATA_WIDTH, default 8, width of one narrow beat in bits.
REQ-003 Parameter MSB_FIRST, default 0: 0 places first beat in lane 0 (LSBs); 1 places first beat in lane DATA_NB-1 (MSBs).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 up_data  input  DATA_WIDTH  narrow beat payload.
REQ-007 up_valid  input  1  upstream beat valid.
REQ-008 up_ready  output  1  packer accepts beat this cycle.
REQ-009 up_last  input  1  beat ends packet.
REQ-010 down_data  output  DATA_NB*DATA_WIDTH  packed word.
REQ-011 down_keep  output  DATA_NB  per-lane valid mask (present only with AXIS_PACKER_KEEP_EN).
REQ-012 down_valid  output  1  packed word valid.
REQ-013 down_ready  input  1  downstream accepts word.
REQ-014 down_last  output  1  word ends packet.

Function
REQ-015 Beat accepted iff up_valid && up_ready at rising edge; word transferred iff down_valid && down_ready.
REQ-016 Lane counter idx (0..DATA_NB-1) selects lane: idx when MSB_FIRST=0, DATA_NB-1-idx when MSB_FIRST=1.
REQ-017 Word completes on accepted beat with idx==DATA_NB-1 or up_last==1; idx returns to 0 after completion, else increments.
REQ-018 Completed word: unfilled lanes zero, keep bit set per filled lane, down_last = up_last of completing beat.
REQ-019 Completing beat loads output register at same edge if !down_valid or down_ready; down_valid high next cycle (1-cycle latency).
REQ-020 Otherwise word held in accumulator, pending=1; up_ready=0 while pending; transfer occurs at first edge with !down_valid or down_ready, then pending=0.
REQ-021 up_ready SHALL be a register output only (no combinational path from up_valid, up_last or down_ready).
REQ-022 Continuous up_valid and down_ready: zero bubbles, one word per DATA_NB input cycles.
REQ-023 Transfer and new word load on same edge: down_valid stays 1, new data presented next cycle.
REQ-024 down_data/keep/last stable while down_valid && !down_ready.
REQ-025 up_last on idx==0 yields single-lane word; up_last on idx==DATA_NB-1 yields full keep with down_last=1.
REQ-026 down_valid drops after transfer when no new word loaded.

Reset
REQ-027 rst low asynchronously clears: idx=0, pending=0, down_valid=0, down_last=0, down_data=0, down_keep=0, accumulator=0.
REQ-028 up_ready=0 while rst low; 1 on first edge after rst deasserts.
REQ-029 Reset mid-word discards partial data; next accepted beat fills first lane.

Configuration
REQ-030 Macro AXIS_PACKER_KEEP_EN defined: down_keep port and keep register present per REQ-018.
REQ-031 Macro undefined: no down_keep port or register; partial words still zero-padded, down_last still marks packet end.

Structure
REQ-032 Shared package axis_pkg holds clog2 function and lane-index width helper; no block-local duplicates.
REQ-033 One sub-module axis_packer_accum: lane counter, accumulator, keep build, completion flag; top holds pending and output register.

Verification (DATA_NB=3, DATA_WIDTH=8)
REQ-034 MSB_FIRST=0, stream 0x01..0x06, down_ready=1 -> words 0x030201, 0x060504, keep 111, last 0 then per up_last.
REQ-035 MSB_FIRST=1, same stream -> words 0x010203, 0x040506.
REQ-036 Stream 0x01..0x05, up_last on 0x05 -> 0x030201 keep 111 last 0, then 0x000504 keep 011 last 1; next packet starts lane 0.
REQ-037 down_ready=0 for 12 cycles, up_valid=1 -> six beats accepted, up_ready=0, down_data 0x030201 held; down_ready=1 -> 0x030201 then 0x060504 back-to-back, up_ready returns 1.
REQ-038 rst low after beats 0x01,0x02 -> all outputs 0; after release, 0x07,0x08,0x09 -> 0x090807.
REQ-039 Single beat 0x0A with up_last -> 0x00000A keep 001 last 1, one cycle after acceptance.
